operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
// - RV32I decode/operand-fetch stage: accepts an instruction from fetch and drives both register_file read ports.
// - Forwards same-cycle writeback data and stalls on pending writes via a 31-entry scoreboard.
// - Registers a decoded bundle (operands, rd, immediate, opcode) for execute under valid/ready.
// - Sits between fetch (upstream) and execute (downstream); snoops the register_file write port.
// PARAMETERS
// - none: widths fixed by RV32I (XLEN=32, 5-bit register addresses)
// PORTS
// clk          in   1   rising-edge clock; the only clock
// rst          in   1   synchronous, active-high reset
// instr_valid  in   1   fetch offers instr/pc
// instr_ready  out  1   stage accepts this cycle (combinational)
// instr        in   32  instruction word
// pc           in   32  address of instr
// rf_rd_addr0  out  5   instr[19:15] (rs1), combinational
// rf_rd_addr1  out  5   instr[24:20] (rs2), combinational
// rf_rd_data0  in   32  register_file read data, port 0
// rf_rd_data1  in   32  register_file read data, port 1
// wb_ena       in   1   writeback enable; same net as register_file wr_ena
// wb_addr      in   5   writeback address
// wb_data      in   32  writeback data
// flush        in   1   discard held bundle (branch redirect)
// out_valid    out  1   bundle valid
// out_ready    in   1   execute accepts bundle
// out_pc, out_instr  out 32 each  registered pc/instr
// out_rs1_val, out_rs2_val  out 32 each  operand values
// out_rd       out  5   destination; 0 if the op does not write rd
// out_imm      out  32  sign-extended immediate (I/S/B/U/J by opcode; 0 otherwise)
// out_opcode   out  7   instr[6:0]
// out_illegal  out  1   opcode not in opcode_t
// BEHAVIOUR
// - Reset: out_valid=0, all out_* =0, scoreboard pending[31:1]=0. x0 never pending.
// - Classes: uses_rs1 = JALR,BRANCH,LOAD,STORE,OP_IMM,OP; uses_rs2 = BRANCH,STORE,OP;
//   writes_rd = LUI,AUIPC,JAL,JALR,LOAD,OP_IMM,OP with rd!=0. Illegal: no uses, no write.
// - busy(r) = pending[r] & ~(wb_ena & wb_addr==r); forwarding cancels the hazard.
// - hazard = (uses_rs1 & busy(rs1)) | (uses_rs2 & busy(rs2)) | (writes_rd & busy(rd)) (WAW stall).
// - instr_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready). issue = instr_valid & instr_ready.
// - Operand = 0 if addr==0; else wb_data if wb_ena & wb_addr==addr; else rf_rd_data.
// - Latency 1: on issue, bundle registered, out_valid=1 next cycle.
// - Hold: out_valid & ~out_ready -> all out_* stable, instr_ready=0.
// - Pop without issue: out_valid -> 0. Pop + issue same cycle: back-to-back, no bubble.
// - Scoreboard: issue & writes_rd sets pending[rd]; wb_ena & wb_addr!=0 clears pending[wb_addr].
//   Set and clear of the same register in one cycle: set wins.
// - flush: out_valid<=0 next cycle; clears pending[out_rd] of the held, unpopped bundle;
//   no issue this cycle. In-flight writes already popped to execute stay pending until wb.
// - Writeback to a non-pending register: data forwarded if matching, no scoreboard error.
// - rst mid-operation: bundle dropped, scoreboard cleared; downstream is reset by the same rst.
// STRUCTURE
// - rv32i_pkg (shared): opcode_t enum (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111,
//   BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, SYSTEM 1110011),
//   imm_fmt_t {IMM_NONE,IMM_I,IMM_S,IMM_B,IMM_U,IMM_J}.
// - Sub-module imm_gen (combinational): instr -> imm_fmt_t + 32-bit immediate.
// - Scoreboard, forwarding, handshake and output register stay in this module.
// TESTING
// 1 After rst: out_valid=0, instr_ready=1 when idle; addi x1,x0,5 (0x00500093) -> next cycle
//   out_rd=1, out_imm=5, out_rs1_val=0, pending[1]=1.
// 2 RAW: add x2,x1,x1 while pending[1] -> instr_ready=0 until wb_ena,wb_addr=1,wb_data=0xDEAD;
//   that cycle issues with out_rs1_val=out_rs2_val=0xDEAD.
// 3 Back-pressure: out_ready=0 for 3 cycles -> bundle stable, instr_ready=0; out_ready=1 with
//   instr_valid=1 -> pop + issue same cycle.
// 4 Immediates: sw 0xFE112E23 -> imm=0xFFFFFFFC; beq 0xFE000EE3 -> imm=0xFFFFFFFC;
//   lui 0xABCDE0B7 -> imm=0xABCDE000; jal 0xFF5FF06F -> imm=0xFFFFFFF4.
// 5 flush with held lw x3 (out_ready=0) -> out_valid=0 next cycle, pending[3]=0, no issue that cycle.
// 6 Same-cycle set/clear: pending[5]=1, wb to x5 while addi x5 issues -> pending[5] stays 1;
//   write to x0 never sets pending, rs=x0 always reads 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode encodings, immediate formats and
// the decoded bundle handed from operand fetch to execute.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic            illegal;
    } bundle_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Signal bundle around the operand-fetch stage: fetch handshake, register
// file read ports, writeback snoop, flush and the decoded bundle to execute.
interface operand_fetch_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;

    logic [4:0]  rf_rd_addr0;
    logic [4:0]  rf_rd_addr1;
    logic [31:0] rf_rd_data0;
    logic [31:0] rf_rd_data1;

    logic        wb_ena;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [6:0]  out_opcode;
    logic        out_illegal;

    // The stage itself.
    modport slave (
        input  instr_valid, instr, pc, rf_rd_data0, rf_rd_data1,
               wb_ena, wb_addr, wb_data, flush, out_ready,
        output instr_ready, rf_rd_addr0, rf_rd_addr1, out_valid, out_pc,
               out_instr, out_rs1_val, out_rs2_val, out_rd, out_imm,
               out_opcode, out_illegal
    );

    // The surrounding pipeline (fetch, register file, execute).
    modport master (
        output instr_valid, instr, pc, rf_rd_data0, rf_rd_data1,
               wb_ena, wb_addr, wb_data, flush, out_ready,
        input  instr_ready, rf_rd_addr0, rf_rd_addr1, out_valid, out_pc,
               out_instr, out_rs1_val, out_rs2_val, out_rd, out_imm,
               out_opcode, out_illegal
    );

endinterface

// File: rtl/operand_fetch_imm_gen.sv
// Combinational immediate generator: classifies the instruction's immediate
// format from its opcode and assembles the sign-extended 32-bit value.
module operand_fetch_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    output imm_fmt_t    fmt_o,
    output logic [31:0] imm_o
);

    // Pick the format by opcode, then assemble the immediate for that format.
    // SYSTEM carries no operand immediate for this stage, so it maps to none.
    always_comb begin
        fmt_o = IMM_NONE;
        case (opcode_t'(instr_i[6:0]))
            LUI, AUIPC:         fmt_o = IMM_U;
            JAL:                fmt_o = IMM_J;
            JALR, LOAD, OP_IMM: fmt_o = IMM_I;
            STORE:              fmt_o = IMM_S;
            BRANCH:             fmt_o = IMM_B;
            default:            fmt_o = IMM_NONE;
        endcase

        imm_o = '0;
        case (fmt_o)
            IMM_I: imm_o = {{21{instr_i[31]}}, instr_i[30:20]};
            IMM_S: imm_o = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
            IMM_B: imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// RV32I decode / operand-fetch stage. Reads both register-file ports,
// forwards same-cycle writeback data, stalls on pending writes tracked by a
// per-register scoreboard and registers a decoded bundle for execute.
module operand_fetch
    import rv32i_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave io
);

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;

    logic [31:0] wb_hit;
    logic [31:0] busy;
    logic        hazard;
    logic        ready;
    logic        issue;
    logic        flush_drop;

    logic [31:1] pending_q;
    logic [31:1] pending_d;
    logic        out_valid_q;
    logic        out_valid_d;
    bundle_t     bundle_q;
    bundle_t     bundle_d;

    imm_fmt_t    imm_fmt;
    logic [31:0] imm_val;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign rs1    = io.instr[19:15];
    assign rs2    = io.instr[24:20];
    assign rd     = io.instr[11:7];
    assign opcode = io.instr[6:0];

    assign io.rf_rd_addr0 = rs1;
    assign io.rf_rd_addr1 = rs2;

    operand_fetch_imm_gen u_imm_gen (
        .instr_i (io.instr),
        .fmt_o   (imm_fmt),
        .imm_o   (imm_val)
    );

    // Decode which register fields the opcode reads and writes.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        case (opcode_t'(opcode))
            LUI, AUIPC, JAL: writes_rd = 1'b1;
            JALR, LOAD, OP_IMM: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            BRANCH, STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            SYSTEM:  illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
        // x0 is hard-wired, so writing it never creates a dependency.
        if (rd == 5'd0) begin
            writes_rd = 1'b0;
        end
    end

    // A held bundle that is flushed before execute takes it will never write
    // back, so its scoreboard entry has to be released here.
    assign flush_drop = io.flush && out_valid_q && !io.out_ready;

    // Per-register writeback match, busy status and scoreboard next state.
    // Setting a bit takes priority over clearing it in the same cycle.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        assign wb_hit[gi] = io.wb_ena && (io.wb_addr == 5'(gi));
        if (gi == 0) begin : g_x0
            assign busy[gi] = 1'b0;
        end else begin : g_xn
            logic set_bit;
            logic clr_bit;
            assign set_bit      = issue && writes_rd && (rd == 5'(gi));
            assign clr_bit      = wb_hit[gi] || (flush_drop && (bundle_q.rd == 5'(gi)));
            assign busy[gi]     = pending_q[gi] && !wb_hit[gi];
            assign pending_d[gi] = set_bit || (pending_q[gi] && !clr_bit);
        end
    end

    // Stall on RAW against either source and on WAW against the destination;
    // a writeback landing this cycle is forwarded and cancels the hazard.
    assign hazard = (uses_rs1 && busy[rs1]) ||
                    (uses_rs2 && busy[rs2]) ||
                    (writes_rd && busy[rd]);

    assign ready = !rst && !io.flush && !hazard && (!out_valid_q || io.out_ready);
    assign issue = io.instr_valid && ready;
    assign io.instr_ready = ready;

    // Operand select: x0 reads zero, a matching writeback beats the register file.
    assign rs1_val = (rs1 == 5'd0) ? '0 : (wb_hit[rs1] ? io.wb_data : io.rf_rd_data0);
    assign rs2_val = (rs2 == 5'd0) ? '0 : (wb_hit[rs2] ? io.wb_data : io.rf_rd_data1);

    // Output bundle next state: load on issue, empty on pop or flush, else hold.
    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (issue) begin
            bundle_d.pc      = io.pc;
            bundle_d.instr   = io.instr;
            bundle_d.rs1_val = rs1_val;
            bundle_d.rs2_val = rs2_val;
            bundle_d.rd      = writes_rd ? rd : 5'd0;
            bundle_d.imm     = (imm_fmt == IMM_NONE) ? '0 : imm_val;
            bundle_d.opcode  = opcode;
            bundle_d.illegal = illegal;
            out_valid_d      = 1'b1;
        end else if (io.flush || io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Bundle, valid flag and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            pending_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            pending_q   <= pending_d;
        end
    end

    assign io.out_valid   = out_valid_q;
    assign io.out_pc      = bundle_q.pc;
    assign io.out_instr   = bundle_q.instr;
    assign io.out_rs1_val = bundle_q.rs1_val;
    assign io.out_rs2_val = bundle_q.rs2_val;
    assign io.out_rd      = bundle_q.rd;
    assign io.out_imm     = bundle_q.imm;
    assign io.out_opcode  = bundle_q.opcode;
    assign io.out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a vector table of decoded instructions plus
// directed sequences for stalls, back-pressure, flush, scoreboard and reset.
module tb_operand_fetch;

    logic clk;
    logic rst;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    exp_t        sb[$];
    exp_t        e_pop;
    exp_t        e_push;
    vec_t        vecs[11];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] regs[32];
    logic [31:0] pc_ctr;
    logic [4:0]  exp_rd_v;
    logic [31:0] exp_imm_v;
    logic        exp_ill_v;
    logic [31:0] held_pc;

    // Register file model; x0 returns garbage so the stage must zero it itself.
    assign bus.rf_rd_data0 = (bus.rf_rd_addr0 == 5'd0) ? 32'hBAD0BAD0 : regs[bus.rf_rd_addr0];
    assign bus.rf_rd_data1 = (bus.rf_rd_addr1 == 5'd0) ? 32'hBAD0BAD0 : regs[bus.rf_rd_addr1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + 32'(i) * 32'h11;
        end else if (bus.wb_ena && bus.wb_addr != 5'd0) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Expected operand: zero for x0, forwarded writeback, else register file.
    function automatic logic [31:0] opnd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.wb_ena && bus.wb_addr == a) return bus.wb_data;
        return regs[a];
    endfunction

    // Scoreboard: push on issue, pop and compare when execute accepts.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", 32'(sb.size()), 1);
                end else begin
                    e_pop = sb.pop_front();
                    check("out_pc", bus.out_pc, e_pop.pc);
                    check("out_instr", bus.out_instr, e_pop.instr);
                    check("out_rs1_val", bus.out_rs1_val, e_pop.rs1);
                    check("out_rs2_val", bus.out_rs2_val, e_pop.rs2);
                    check("out_rd", 32'(bus.out_rd), 32'(e_pop.rd));
                    check("out_imm", bus.out_imm, e_pop.imm);
                    check("out_opcode", 32'(bus.out_opcode), 32'(e_pop.opc));
                    check("out_illegal", 32'(bus.out_illegal), 32'(e_pop.ill));
                    $display("pop   pc=%h instr=%h rd=%0d imm=%h rs1=%h rs2=%h",
                             bus.out_pc, bus.out_instr, bus.out_rd, bus.out_imm,
                             bus.out_rs1_val, bus.out_rs2_val);
                end
            end else if (bus.flush && bus.out_valid && sb.size() > 0) begin
                e_pop = sb.pop_front();
                $display("drop  pc=%h instr=%h (flushed)", e_pop.pc, e_pop.instr);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                e_push.pc    = bus.pc;
                e_push.instr = bus.instr;
                e_push.rs1   = opnd(bus.instr[19:15]);
                e_push.rs2   = opnd(bus.instr[24:20]);
                e_push.rd    = exp_rd_v;
                e_push.imm   = exp_imm_v;
                e_push.opc   = bus.instr[6:0];
                e_push.ill   = exp_ill_v;
                sb.push_back(e_push);
                $display("issue pc=%h instr=%h", bus.pc, bus.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [4:0] rd,
                         input logic [31:0] imm, input logic ill);
        bus.instr       = ins;
        bus.pc          = pc_ctr;
        pc_ctr          = pc_ctr + 32'd4;
        exp_rd_v        = rd;
        exp_imm_v       = imm;
        exp_ill_v       = ill;
        bus.instr_valid = 1'b1;
    endtask

    task automatic wait_issue(input string nm);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check(nm, 32'(ok), 1);
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_ena  = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        tick();
        bus.wb_ena  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 5'd1, 32'h00000005, 1'b0}; // addi x1,x0,5
        vecs[1]  = '{32'hFE112E23, 5'd0, 32'hFFFFFFFC, 1'b0}; // sw x1,-4(x2)
        vecs[2]  = '{32'hFE000EE3, 5'd0, 32'hFFFFFFFC, 1'b0}; // beq x0,x0,-4
        vecs[3]  = '{32'hABCDE0B7, 5'd1, 32'hABCDE000, 1'b0}; // lui x1
        vecs[4]  = '{32'hFF5FF06F, 5'd0, 32'hFFFFFFF4, 1'b0}; // jal x0,-12
        vecs[5]  = '{32'h00108133, 5'd2, 32'h00000000, 1'b0}; // add x2,x1,x1
        vecs[6]  = '{32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b1}; // illegal
        vecs[7]  = '{32'h0080A183, 5'd3, 32'h00000008, 1'b0}; // lw x3,8(x1)
        vecs[8]  = '{32'h12345217, 5'd4, 32'h12345000, 1'b0}; // auipc x4
        vecs[9]  = '{32'hFFF302E7, 5'd5, 32'hFFFFFFFF, 1'b0}; // jalr x5,-1(x6)
        vecs[10] = '{32'h00100013, 5'd0, 32'h00000001, 1'b0}; // addi x0,x0,1

        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.pc = '0;
        bus.wb_ena = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        pc_ctr = 32'h0000_0100;
        exp_rd_v = '0;
        exp_imm_v = '0;
        exp_ill_v = 1'b0;
        held_pc = '0;

        // Reset state.
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_instr_ready", 32'(bus.instr_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_instr_ready", 32'(bus.instr_ready), 1);
        check("idle_out_valid", 32'(bus.out_valid), 0);
        tick();

        // Vector table; each destination is written back before moving on.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].instr, vecs[i].rd, vecs[i].imm, vecs[i].ill);
            wait_issue("vec_issue");
            if (vecs[i].rd != 5'd0) do_wb(vecs[i].rd, 32'hC0DE_0000 + 32'(i));
        end
        tick();

        // RAW stall released by a forwarded writeback.
        drive(32'h00500093, 5'd1, 32'd5, 1'b0);
        wait_issue("t2_addi_x1");
        drive(32'h00108133, 5'd2, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_raw_stall", 32'(bus.instr_ready), 0);
            tick();
        end
        bus.wb_ena = 1'b1;
        bus.wb_addr = 5'd1;
        bus.wb_data = 32'h0000DEAD;
        @(negedge clk);
        check("t2_fwd_ready", 32'(bus.instr_ready), 1);
        tick();
        bus.wb_ena = 1'b0;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("t2_rs1_fwd", bus.out_rs1_val, 32'h0000DEAD);
        check("t2_rs2_fwd", bus.out_rs2_val, 32'h0000DEAD);
        tick();
        do_wb(5'd2, 32'h2222_2222);

        // Back-pressure: bundle held three cycles, then pop + issue together.
        bus.out_ready = 1'b0;
        held_pc = pc_ctr;
        drive(32'h0080A183, 5'd3, 32'd8, 1'b0);
        wait_issue("t3_lw_issue");
        drive(32'h00700313, 5'd6, 32'd7, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.out_valid), 1);
            check("t3_hold_rd", 32'(bus.out_rd), 3);
            check("t3_hold_pc", bus.out_pc, held_pc);
            check("t3_hold_ready", 32'(bus.instr_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t3_pop_issue_ready", 32'(bus.instr_ready), 1);
        tick();
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("t3_b2b_valid", 32'(bus.out_valid), 1);
        check("t3_b2b_rd", 32'(bus.out_rd), 6);
        tick();
        do_wb(5'd3, 32'h3333_3333);
        do_wb(5'd6, 32'h6666_6666);

        // Flush of a held lw x3: valid drops, x3 released, nothing issues.
        bus.out_ready = 1'b0;
        drive(32'h0080A183, 5'd3, 32'd8, 1'b0);
        wait_issue("t5_lw_issue");
        bus.flush = 1'b1;
        drive(32'h00100393, 5'd7, 32'd1, 1'b0);
        @(negedge clk);
        check("t5_flush_no_issue", 32'(bus.instr_ready), 0);
        tick();
        bus.flush = 1'b0;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("t5_flush_valid", 32'(bus.out_valid), 0);
        tick();
        bus.out_ready = 1'b1;
        drive(32'h00318433, 5'd8, 32'd0, 1'b0);
        @(negedge clk);
        check("t5_x3_released", 32'(bus.instr_ready), 1);
        tick();
        bus.instr_valid = 1'b0;
        do_wb(5'd8, 32'h8888_8888);

        // Same-cycle set and clear of x5: the new write keeps x5 pending.
        drive(32'h00300293, 5'd5, 32'd3, 1'b0);
        wait_issue("t6_addi_x5");
        drive(32'h00900293, 5'd5, 32'd9, 1'b0);
        @(negedge clk);
        check("t6_waw_stall", 32'(bus.instr_ready), 0);
        tick();
        bus.wb_ena = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'h0000_0055;
        @(negedge clk);
        check("t6_wb_unstall", 32'(bus.instr_ready), 1);
        tick();
        bus.wb_ena = 1'b0;
        drive(32'h000284B3, 5'd9, 32'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t6_set_wins", 32'(bus.instr_ready), 0);
            tick();
        end
        bus.wb_ena = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'h0000_0066;
        @(negedge clk);
        check("t6_x5_fwd_ready", 32'(bus.instr_ready), 1);
        tick();
        bus.wb_ena = 1'b0;
        bus.instr_valid = 1'b0;
        do_wb(5'd9, 32'h9999_9999);

        // x0: writing it never stalls, reading it is zero even with a wb to x0.
        drive(32'h00100013, 5'd0, 32'd1, 1'b0);
        wait_issue("t6_addi_x0");
        drive(32'h00000533, 5'd10, 32'd0, 1'b0);
        bus.wb_ena = 1'b1;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'h0000_1234;
        @(negedge clk);
        check("t6_x0_never_pending", 32'(bus.instr_ready), 1);
        tick();
        bus.wb_ena = 1'b0;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("t6_x0_rs1", bus.out_rs1_val, 32'h0);
        check("t6_x0_rs2", bus.out_rs2_val, 32'h0);
        tick();
        do_wb(5'd10, 32'hAAAA_AAAA);

        // Reset mid-operation drops the bundle and clears the scoreboard.
        bus.out_ready = 1'b0;
        drive(32'hABCDE5B7, 5'd11, 32'hABCDE000, 1'b0);
        wait_issue("t7_lui_x11");
        rst = 1'b1;
        @(negedge clk);
        check("t7_rst_ready", 32'(bus.instr_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t7_rst_valid", 32'(bus.out_valid), 0);
        check("t7_rst_rd", 32'(bus.out_rd), 0);
        check("t7_rst_imm", bus.out_imm, 32'h0);
        check("t7_rst_pc", bus.out_pc, 32'h0);
        tick();
        bus.out_ready = 1'b1;
        drive(32'h00B58633, 5'd12, 32'd0, 1'b0);
        @(negedge clk);
        check("t7_x11_cleared", 32'(bus.instr_ready), 1);
        tick();
        bus.instr_valid = 1'b0;
        do_wb(5'd12, 32'hCCCC_CCCC);

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
